// File: rtl/clint_bram_arbiter_if.sv
// Request/response bus between the uncore requesters and the CLINT BRAM arbiter.
// One lane per requester; the response data bus is shared and qualified by resp_valid.
interface clint_bram_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0][15:0]  req_addr;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_wide;
    logic [NUM_REQ-1:0][63:0]  req_wrdata;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [63:0]               resp_rddata;

    modport master (
        output req_valid, req_addr, req_we, req_wide, req_wrdata,
        input  req_ready, resp_valid, resp_rddata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wide, req_wrdata,
        output req_ready, resp_valid, resp_rddata
    );
endinterface

// File: rtl/clint_bram_arbiter.sv
// CLINT BRAM arbiter: round-robin grant among NUM_REQ requesters, then sequences
// one narrow access or a multi-access wide read/write on the 32-bit BRAM port.
// Wide reads use hi/lo/hi re-read so a rolling mtime is never returned torn;
// wide writes park the low word at all-ones first so mtimecmp never dips below mtime.
module clint_bram_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    clint_bram_arbiter_if.slave req_bus,
    output logic [15:0]        bram_addr,
    output logic               bram_en,
    output logic               bram_we,
    output logic [31:0]        bram_wrdata,
    input  logic [31:0]        bram_rddata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        IDLE,
        N_ACC,
        N_CAP,
        W_LO1,
        W_HI,
        W_LO2,
        R_HI,
        R_LO,
        R_HI2,
        R_CHK,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   owner_q;
    logic [15:2]        addr_q;
    logic               we_q;
    logic               wide_q;
    logic [63:0]        wrdata_q;
    logic [31:0]        hi1_q;
    logic [31:0]        lo_q;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;
    logic [15:0]        wide_lo_addr;
    logic [15:0]        wide_hi_addr;

    assign wide_lo_addr = {addr_q[15:3], 3'b000};
    assign wide_hi_addr = {addr_q[15:3], 3'b100};
    assign accept       = (state_q == IDLE) && grant_found && !rst;

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found && req_bus.req_valid[(int'(last_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    // One-hot ready to the winner, only while idle and out of reset.
    always_comb begin
        req_bus.req_ready = '0;
        if (accept) begin
            req_bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and BRAM/response outputs, driven purely from state and captured registers.
    always_comb begin
        state_d             = state_q;
        bram_en             = 1'b0;
        bram_we             = 1'b0;
        bram_addr           = 16'h0000;
        bram_wrdata         = 32'h0000_0000;
        req_bus.resp_valid  = '0;
        req_bus.resp_rddata = 64'h0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bus.req_wide[grant_idx] && req_bus.req_we[grant_idx]) begin
                        state_d = W_LO1;
                    end else if (req_bus.req_wide[grant_idx]) begin
                        state_d = R_HI;
                    end else begin
                        state_d = N_ACC;
                    end
                end
            end
            N_ACC: begin
                bram_en     = 1'b1;
                bram_we     = we_q;
                bram_addr   = {addr_q[15:2], 2'b00};
                bram_wrdata = wrdata_q[31:0];
                state_d     = N_CAP;
            end
            N_CAP: begin
                state_d = RESP;
            end
            W_LO1: begin
                bram_en     = 1'b1;
                bram_we     = 1'b1;
                bram_addr   = wide_lo_addr;
                bram_wrdata = 32'hFFFF_FFFF;
                state_d     = W_HI;
            end
            W_HI: begin
                bram_en     = 1'b1;
                bram_we     = 1'b1;
                bram_addr   = wide_hi_addr;
                bram_wrdata = wrdata_q[63:32];
                state_d     = W_LO2;
            end
            W_LO2: begin
                bram_en     = 1'b1;
                bram_we     = 1'b1;
                bram_addr   = wide_lo_addr;
                bram_wrdata = wrdata_q[31:0];
                state_d     = RESP;
            end
            R_HI: begin
                bram_en   = 1'b1;
                bram_addr = wide_hi_addr;
                state_d   = R_LO;
            end
            R_LO: begin
                bram_en   = 1'b1;
                bram_addr = wide_lo_addr;
                state_d   = R_HI2;
            end
            R_HI2: begin
                bram_en   = 1'b1;
                bram_addr = wide_hi_addr;
                state_d   = R_CHK;
            end
            R_CHK: begin
                if (bram_rddata == hi1_q) begin
                    state_d = RESP;
                end else begin
                    state_d = R_LO;
                end
            end
            RESP: begin
                req_bus.resp_valid[owner_q] = 1'b1;
                if (we_q) begin
                    req_bus.resp_rddata = 64'h0;
                end else if (wide_q) begin
                    req_bus.resp_rddata = {hi1_q, lo_q};
                end else begin
                    req_bus.resp_rddata = {32'h0000_0000, lo_q};
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, arbitration history, captured request and read-back words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= IDX_W'(NUM_REQ - 1);
            owner_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wide_q   <= 1'b0;
            wrdata_q <= 64'h0;
            hi1_q    <= 32'h0;
            lo_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q  <= grant_idx;
                last_q   <= grant_idx;
                addr_q   <= req_bus.req_addr[grant_idx][15:2];
                we_q     <= req_bus.req_we[grant_idx];
                wide_q   <= req_bus.req_wide[grant_idx];
                wrdata_q <= req_bus.req_wrdata[grant_idx];
            end
            case (state_q)
                N_CAP: lo_q  <= bram_rddata;
                R_LO:  hi1_q <= bram_rddata;
                R_HI2: lo_q  <= bram_rddata;
                R_CHK: begin
                    if (bram_rddata != hi1_q) begin
                        hi1_q <= bram_rddata;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clint_bram_arbiter.sv
// Directed bench for clint_bram_arbiter with a behavioural 1-cycle-latency BRAM
// holding msip / mtimecmp / mtime words.
module tb_clint_bram_arbiter;
    localparam int NUM_REQ = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bram_addr;
    logic        bram_en;
    logic        bram_we;
    logic [31:0] bram_wrdata;
    logic [31:0] bram_rddata;

    int n_checks = 0;
    int n_fail   = 0;

    clint_bram_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    clint_bram_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_bus     (bus),
        .bram_addr   (bram_addr),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_wrdata (bram_wrdata),
        .bram_rddata (bram_rddata)
    );

    always #5 clk = ~clk;

    bit   [31:0] mem [0:16383];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0;
    logic [63:0] poke_data = 64'h0;
    logic [48:0] acc_log [$];
    logic        mtip_watch = 1'b0;
    int          mtip_count = 0;

    // BRAM model: registered read, write-through, plus a 64-bit backdoor for mtime updates.
    always @(posedge clk) begin
        if (bram_en) begin
            bram_rddata <= mem[bram_addr[15:2]];
            if (bram_we) mem[bram_addr[15:2]] <= bram_wrdata;
            acc_log.push_back({bram_we, bram_addr, bram_wrdata});
        end
        if (poke_en) begin
            mem[{poke_addr[15:3], 1'b0}] <= poke_data[31:0];
            mem[{poke_addr[15:3], 1'b1}] <= poke_data[63:32];
        end
    end

    // mtip watch for hart 0: mtime (0xBFF8) >= mtimecmp (0x4000).
    always @(negedge clk) begin
        if (mtip_watch && ({mem[14'h2FFF], mem[14'h2FFE]} >= {mem[14'h1001], mem[14'h1000]}))
            mtip_count <= mtip_count + 1;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke64(input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // Issue one request, wait for grant and completion; latencies are counted from acceptance cycle T.
    task automatic applyStimulus(input int idx, input logic [15:0] addr, input logic we,
                                 input logic wide, input logic [63:0] wdata,
                                 output int en_lat, output int resp_lat,
                                 output logic [63:0] rdata, output logic [15:0] first_addr);
        int  w;
        int  lat;
        bit  got;
        en_lat = 0; resp_lat = 0; rdata = 64'h0; first_addr = 16'h0;
        @(negedge clk);
        bus.req_valid[idx]  = 1'b1;
        bus.req_addr[idx]   = addr;
        bus.req_we[idx]     = we;
        bus.req_wide[idx]   = wide;
        bus.req_wrdata[idx] = wdata;
        got = 1'b0;
        w   = 0;
        while (!got && w < 20) begin
            #1;
            if (bus.req_ready[idx]) got = 1'b1;
            else begin
                @(negedge clk);
                w++;
            end
        end
        checkOutput($sformatf("grant_req%0d", idx), 64'(got), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        lat = 1;
        while (resp_lat == 0 && lat < 30) begin
            #1;
            if (bram_en && en_lat == 0) begin
                en_lat     = lat;
                first_addr = bram_addr;
            end
            if (bus.resp_valid[idx]) begin
                resp_lat = lat;
                rdata    = bus.resp_rddata;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    initial begin
        int          en_lat;
        int          resp_lat;
        logic [63:0] rdata;
        logic [15:0] faddr;
        int          log0;
        int          mtip0;
        int          resp_seen;
        int          viol;
        int          ngrant;
        int          gidx [8];
        int          gcyc [8];
        int          first_resp0;
        int          first_resp1;
        bit          got;
        int          w;

        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_we     = '0;
        bus.req_wide   = '0;
        bus.req_wrdata = '0;

        // Reset state, with both requesters pending to show ready is held low.
        bus.req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_ready",   64'(bus.req_ready),   64'h0);
        checkOutput("rst_resp_valid",  64'(bus.resp_valid),  64'h0);
        checkOutput("rst_resp_rddata", bus.resp_rddata,      64'h0);
        checkOutput("rst_bram_en",     64'(bram_en),         64'h0);
        checkOutput("rst_bram_we",     64'(bram_we),         64'h0);
        checkOutput("rst_bram_addr",   64'(bram_addr),       64'h0);
        checkOutput("rst_bram_wrdata", 64'(bram_wrdata),     64'h0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        poke64(16'h0000, 64'h0000_0000_0000_0001);
        poke64(16'hBFF8, 64'h0000_0000_0000_0005);
        poke64(16'h4000, 64'hFFFF_FFFF_FFFF_FFFF);

        // Narrow read of msip[0].
        applyStimulus(0, 16'h0000, 1'b0, 1'b0, 64'h0, en_lat, resp_lat, rdata, faddr);
        checkOutput("nrd_en_lat",  64'(en_lat),   64'd1);
        checkOutput("nrd_addr",    64'(faddr),    64'h0000);
        checkOutput("nrd_resp_lat",64'(resp_lat), 64'd3);
        checkOutput("nrd_rddata",  rdata,         64'h0000_0000_0000_0001);

        // Wide write of mtimecmp while mtime = 5.
        log0  = acc_log.size();
        mtip0 = mtip_count;
        mtip_watch = 1'b1;
        applyStimulus(1, 16'h4000, 1'b1, 1'b1, 64'h0000_0001_2345_6789, en_lat, resp_lat, rdata, faddr);
        @(negedge clk);
        mtip_watch = 1'b0;
        checkOutput("wwr_en_lat",   64'(en_lat),   64'd1);
        checkOutput("wwr_resp_lat", 64'(resp_lat), 64'd4);
        checkOutput("wwr_rddata",   rdata,         64'h0);
        checkOutput("wwr_nacc",     64'(acc_log.size() - log0), 64'd3);
        checkOutput("wwr_acc0", 64'(acc_log[log0]),     {15'h0, 1'b1, 16'h4000, 32'hFFFF_FFFF});
        checkOutput("wwr_acc1", 64'(acc_log[log0 + 1]), {15'h0, 1'b1, 16'h4004, 32'h0000_0001});
        checkOutput("wwr_acc2", 64'(acc_log[log0 + 2]), {15'h0, 1'b1, 16'h4000, 32'h2345_6789});
        checkOutput("wwr_mtip_pulses", 64'(mtip_count - mtip0), 64'd0);

        // Tear-free read: mtime rolls over right after the first hi read.
        poke64(16'hBFF8, 64'h0000_0000_FFFF_FFFF);
        log0 = acc_log.size();
        fork
            applyStimulus(0, 16'hBFF8, 1'b0, 1'b1, 64'h0, en_lat, resp_lat, rdata, faddr);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (bram_en && bram_addr == 16'hBFFC) break;
                end
                poke_addr = 16'hBFF8;
                poke_data = 64'h0000_0001_0000_0000;
                poke_en   = 1'b1;
                @(negedge clk);
                poke_en   = 1'b0;
            end
        join
        checkOutput("tear_resp_lat", 64'(resp_lat), 64'd8);
        checkOutput("tear_rddata",   rdata,         64'h0000_0001_0000_0000);
        checkOutput("tear_nacc",     64'(acc_log.size() - log0), 64'd5);

        // Address masking on narrow write and wide read.
        log0 = acc_log.size();
        applyStimulus(1, 16'h0003, 1'b1, 1'b0, 64'h1, en_lat, resp_lat, rdata, faddr);
        checkOutput("mask_nwr_addr",     64'(faddr),    64'h0000);
        checkOutput("mask_nwr_resp_lat", 64'(resp_lat), 64'd3);
        checkOutput("mask_nwr_acc",      64'(acc_log[log0]), {15'h0, 1'b1, 16'h0000, 32'h0000_0001});
        log0 = acc_log.size();
        applyStimulus(0, 16'h4004, 1'b0, 1'b1, 64'h0, en_lat, resp_lat, rdata, faddr);
        checkOutput("mask_wrd_resp_lat", 64'(resp_lat), 64'd5);
        checkOutput("mask_wrd_a0", 64'(acc_log[log0][47:32]),     64'h4004);
        checkOutput("mask_wrd_a1", 64'(acc_log[log0 + 1][47:32]), 64'h4000);
        checkOutput("mask_wrd_a2", 64'(acc_log[log0 + 2][47:32]), 64'h4004);
        checkOutput("mask_wrd_rddata", rdata, 64'h0000_0001_2345_6789);

        // Reset in the middle of a wide write (during W_HI).
        @(negedge clk);
        bus.req_valid[0]  = 1'b1;
        bus.req_addr[0]   = 16'h4000;
        bus.req_we[0]     = 1'b1;
        bus.req_wide[0]   = 1'b1;
        bus.req_wrdata[0] = 64'hAAAA_AAAA_5555_5555;
        got = 1'b0;
        w   = 0;
        while (!got && w < 20) begin
            #1;
            if (bus.req_ready[0]) got = 1'b1;
            else begin
                @(negedge clk);
                w++;
            end
        end
        checkOutput("mid_grant", 64'(got), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("mid_whi_addr", 64'(bram_addr), 64'h4004);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_bram_en", 64'(bram_en), 64'd0);
        resp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            #1;
            if (|bus.resp_valid) resp_seen++;
        end
        checkOutput("mid_no_resp", 64'(resp_seen), 64'd0);

        // Round-robin with both requesters continuously pending.
        bus.req_addr[0] = 16'h0000; bus.req_we[0] = 1'b0; bus.req_wide[0] = 1'b0;
        bus.req_addr[1] = 16'h0004; bus.req_we[1] = 1'b0; bus.req_wide[1] = 1'b0;
        viol = 0; ngrant = 0; first_resp0 = -1; first_resp1 = -1;
        for (int i = 0; i < 8; i++) begin
            gidx[i] = -1;
            gcyc[i] = -1;
        end
        @(negedge clk);
        bus.req_valid = 2'b11;
        for (int c = 0; c < 20; c++) begin
            #1;
            if ($countones(bus.req_ready) > 1) viol++;
            if (bus.req_ready != 2'b00 && ngrant < 8) begin
                gidx[ngrant] = bus.req_ready[1] ? 1 : 0;
                gcyc[ngrant] = c;
                ngrant++;
            end
            if (bus.resp_valid[0] && first_resp0 < 0) first_resp0 = c;
            if (bus.resp_valid[1] && first_resp1 < 0) first_resp1 = c;
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        checkOutput("rr_ngrant",  64'(ngrant),  64'd5);
        checkOutput("rr_onehot",  64'(viol),    64'd0);
        checkOutput("rr_g0", 64'(gidx[0]), 64'd0);
        checkOutput("rr_g1", 64'(gidx[1]), 64'd1);
        checkOutput("rr_g2", 64'(gidx[2]), 64'd0);
        checkOutput("rr_g3", 64'(gidx[3]), 64'd1);
        checkOutput("rr_gap01", 64'(gcyc[1] - gcyc[0]), 64'd4);
        checkOutput("rr_gap12", 64'(gcyc[2] - gcyc[1]), 64'd4);
        checkOutput("rr_resp0_lat", 64'(first_resp0 - gcyc[0]), 64'd3);
        checkOutput("rr_resp1_lat", 64'(first_resp1 - gcyc[1]), 64'd3);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
